// File: rtl/fractal_sync_requester.sv
// Core-side initiator of the fractal sync protocol: buffers barrier requests,
// issues one at a time on the sync network and returns completions in order.
module fractal_sync_requester #(
  parameter int unsigned LVL_WIDTH      = 1,
  parameter int unsigned ID_WIDTH       = 1,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  input  logic [LVL_WIDTH-1:0] core_req_level_i,
  input  logic [ID_WIDTH-1:0]  core_req_id_i,
  output logic                 core_rsp_valid_o,
  input  logic                 core_rsp_ready_i,
  output logic [ID_WIDTH-1:0]  core_rsp_id_o,
  output logic                 core_rsp_err_o,
  output logic                 sync_req_valid_o,
  input  logic                 sync_req_ready_i,
  output logic [LVL_WIDTH-1:0] sync_req_level_o,
  output logic [ID_WIDTH-1:0]  sync_req_id_o,
  input  logic                 sync_rsp_valid_i,
  input  logic [LVL_WIDTH-1:0] sync_rsp_level_i,
  input  logic [ID_WIDTH-1:0]  sync_rsp_id_i,
  input  logic                 sync_rsp_err_i,
  output logic                 busy_o,
  output logic                 stray_o,
  output logic                 timeout_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit               WD_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RSP} state_t;

  state_t state, state_next;

  logic [LVL_WIDTH-1:0] fifo_level [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]  fifo_id    [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, empty, push, pop;

  logic [LVL_WIDTH-1:0] cur_level;
  logic [ID_WIDTH-1:0]  cur_id;
  logic                 cur_err;
  logic [WD_W-1:0]      wd_count;
  logic                 match, expire;
  logic                 stray_q, timeout_q;

  // Ready is derived from the registered count only, so a same-cycle pop never frees a slot early.
  assign full             = (count == CNT_FULL);
  assign empty            = (count == '0);
  assign core_req_ready_o = !rst_i && !full;
  assign push             = core_req_valid_i && core_req_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_level[i] <= '0;
        fifo_id[i]    <= '0;
      end
    end else begin
      if (push) begin
        fifo_level[wr_ptr] <= core_req_level_i;
        fifo_id[wr_ptr]    <= core_req_id_i;
        wr_ptr             <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A response matching on the expiry cycle takes priority over the watchdog.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    match      = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (sync_req_ready_i) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        match  = sync_rsp_valid_i && (sync_rsp_level_i == cur_level) && (sync_rsp_id_i == cur_id);
        expire = WD_EN && (wd_count == WD_LAST) && !match;
        if (match || expire) begin
          state_next = S_RSP;
        end
      end
      S_RSP: begin
        if (core_rsp_ready_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_level <= '0;
      cur_id    <= '0;
      cur_err   <= 1'b0;
      wd_count  <= '0;
      stray_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      stray_q   <= sync_rsp_valid_i && !match;
      timeout_q <= expire;
      if (pop) begin
        cur_level <= fifo_level[rd_ptr];
        cur_id    <= fifo_id[rd_ptr];
        cur_err   <= 1'b0;
      end else if (match) begin
        cur_err <= sync_rsp_err_i;
      end else if (expire) begin
        cur_err <= 1'b1;
      end
      if (state == S_REQ) begin
        wd_count <= '0;
      end else if (state == S_WAIT) begin
        wd_count <= wd_count + WD_W'(1);
      end
    end
  end

  assign sync_req_valid_o = (state == S_REQ);
  assign sync_req_level_o = cur_level;
  assign sync_req_id_o    = cur_id;
  assign core_rsp_valid_o = (state == S_RSP);
  assign core_rsp_id_o    = cur_id;
  assign core_rsp_err_o   = cur_err;
  assign busy_o           = (state != S_IDLE) || !empty;
  assign stray_o          = stray_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_fractal_sync_requester.sv
// Bench for fractal_sync_requester: directed protocol scenarios, then random
// traffic scored against an in-order completion queue filled at issue time.
module tb_fractal_sync_requester;

  localparam int LVL_W  = 2;
  localparam int ID_W   = 3;
  localparam int DEPTH  = 2;
  localparam int TMO    = 8;
  localparam int N_RAND = 40;

  typedef struct {
    logic [ID_W-1:0] id;
    logic            err;
  } exp_t;

  typedef struct {
    logic [LVL_W-1:0] level;
    logic [ID_W-1:0]  id;
    int               rsp_at;
    logic             err;
  } plan_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             core_req_valid_i = 1'b0;
  logic             core_req_ready_o;
  logic [LVL_W-1:0] core_req_level_i = '0;
  logic [ID_W-1:0]  core_req_id_i = '0;
  logic             core_rsp_valid_o;
  logic             core_rsp_ready_i = 1'b1;
  logic [ID_W-1:0]  core_rsp_id_o;
  logic             core_rsp_err_o;
  logic             sync_req_valid_o;
  logic             sync_req_ready_i = 1'b0;
  logic [LVL_W-1:0] sync_req_level_o;
  logic [ID_W-1:0]  sync_req_id_o;
  logic             sync_rsp_valid_i = 1'b0;
  logic [LVL_W-1:0] sync_rsp_level_i = '0;
  logic [ID_W-1:0]  sync_rsp_id_i = '0;
  logic             sync_rsp_err_i = 1'b0;
  logic             busy_o;
  logic             stray_o;
  logic             timeout_o;

  int    checks = 0;
  int    passes = 0;
  int    stray_seen = 0;
  int    timeout_seen = 0;
  int    exp_stray = 0;
  int    exp_timeout = 0;
  bit    net_done = 1'b0;
  exp_t  exp_q[$];
  plan_t plan_q[$];

  fractal_sync_requester #(
    .LVL_WIDTH(LVL_W),
    .ID_WIDTH(ID_W),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .core_req_valid_i(core_req_valid_i),
    .core_req_ready_o(core_req_ready_o),
    .core_req_level_i(core_req_level_i),
    .core_req_id_i(core_req_id_i),
    .core_rsp_valid_o(core_rsp_valid_o),
    .core_rsp_ready_i(core_rsp_ready_i),
    .core_rsp_id_o(core_rsp_id_o),
    .core_rsp_err_o(core_rsp_err_o),
    .sync_req_valid_o(sync_req_valid_o),
    .sync_req_ready_i(sync_req_ready_i),
    .sync_req_level_o(sync_req_level_o),
    .sync_req_id_o(sync_req_id_o),
    .sync_rsp_valid_i(sync_rsp_valid_i),
    .sync_rsp_level_i(sync_rsp_level_i),
    .sync_rsp_id_i(sync_rsp_id_i),
    .sync_rsp_err_i(sync_rsp_err_i),
    .busy_o(busy_o),
    .stray_o(stray_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic recordFail(input string name, input string detail);
    checks++;
    $display("[TB] FAIL %s: %s", name, detail);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveRsp(input logic [LVL_W-1:0] lvl, input logic [ID_W-1:0] id_v, input logic err);
    sync_rsp_valid_i = 1'b1;
    sync_rsp_level_i = lvl;
    sync_rsp_id_i    = id_v;
    sync_rsp_err_i   = err;
  endtask

  task automatic waitReqValid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (sync_req_valid_o) begin
        ok = 1'b1;
        return;
      end
      step();
    end
    recordFail("sync_req_wait", "got no sync_req_valid_o within 300 cycles, expected one");
  endtask

  // Pushes one core request; when tracked, its completion is queued for the monitor.
  task automatic applyStimulus(input logic [LVL_W-1:0] lvl, input logic [ID_W-1:0] id_v,
                               input logic err, input bit track);
    int k;
    k = 0;
    core_req_valid_i = 1'b1;
    core_req_level_i = lvl;
    core_req_id_i    = id_v;
    while (!core_req_ready_o && k < 300) begin
      step();
      k++;
    end
    if (!core_req_ready_o) begin
      recordFail("core_req_wait", "got core_req_ready_o=0 for 300 cycles, expected 1");
      core_req_valid_i = 1'b0;
      return;
    end
    if (track) exp_q.push_back('{id: id_v, err: err});
    step();
    core_req_valid_i = 1'b0;
  endtask

  // Network side of one barrier; rsp_at counts edges after the request handshake, 0 means silence.
  task automatic serveOne(input logic [LVL_W-1:0] lvl, input logic [ID_W-1:0] id_v,
                          input int rsp_at, input logic err, input int span);
    bit ok;
    bit timed_out;
    int done_at;
    timed_out = (rsp_at == 0) || (rsp_at > TMO);
    done_at   = timed_out ? TMO : rsp_at;
    waitReqValid(ok);
    if (!ok) return;
    checkOutput("req_level", sync_req_level_o, lvl);
    checkOutput("req_id", sync_req_id_o, id_v);
    sync_req_ready_i = 1'b1;
    step();
    sync_req_ready_i = 1'b0;
    for (int j = 1; j <= span; j++) begin
      if (j == rsp_at) driveRsp(lvl, id_v, err);
      step();
      sync_rsp_valid_i = 1'b0;
      checkOutput("timeout_pulse", timeout_o, timed_out && (j == TMO));
      if (j < done_at) checkOutput("rsp_early", core_rsp_valid_o, 0);
      if (j == done_at) begin
        checkOutput("rsp_valid", core_rsp_valid_o, 1);
        checkOutput("rsp_id_direct", core_rsp_id_o, id_v);
        checkOutput("rsp_err_direct", core_rsp_err_o, timed_out ? 1'b1 : err);
      end
    end
  endtask

  // Scoreboard monitor: every completion handshake is compared against the head of the queue.
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_i) begin
      if (stray_o) stray_seen++;
      if (timeout_o) timeout_seen++;
      if (core_rsp_valid_o && core_rsp_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_completion: got id %0h err %0b, expected none", core_rsp_id_o, core_rsp_err_o);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_rsp_id", core_rsp_id_o, e.id);
          checkOutput("sb_rsp_err", core_rsp_err_o, e.err);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    bit ok;
    int s0;
    int t0;

    rst_i = 1'b1;
    step();
    step();
    checkOutput("reset_ready", core_req_ready_o, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_sync_valid", sync_req_valid_o, 0);
    checkOutput("reset_rsp_valid", core_rsp_valid_o, 0);
    rst_i = 1'b0;
    #1;
    checkOutput("ready_after_reset", core_req_ready_o, 1);

    $display("[TB] single barrier");
    applyStimulus(2'd1, 3'd3, 1'b0, 1'b1);
    checkOutput("req_latency_c1", sync_req_valid_o, 0);
    step();
    checkOutput("req_latency_c2", sync_req_valid_o, 1);
    serveOne(2'd1, 3'd3, 5, 1'b0, 6);
    checkOutput("idle_busy", busy_o, 0);
    checkOutput("idle_rsp_valid", core_rsp_valid_o, 0);

    $display("[TB] backpressure and ordering");
    applyStimulus(2'd0, 3'd1, 1'b0, 1'b1);
    applyStimulus(2'd1, 3'd2, 1'b0, 1'b1);
    checkOutput("ready_before_third", core_req_ready_o, 1);
    applyStimulus(2'd2, 3'd3, 1'b0, 1'b1);
    checkOutput("ready_when_full", core_req_ready_o, 0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("req_hold_valid", sync_req_valid_o, 1);
      checkOutput("req_hold_id", sync_req_id_o, 1);
      step();
    end
    serveOne(2'd0, 3'd1, 2, 1'b0, 3);
    serveOne(2'd1, 3'd2, 1, 1'b0, 2);
    serveOne(2'd2, 3'd3, 4, 1'b0, 5);

    $display("[TB] stray and mismatch");
    applyStimulus(2'd1, 3'd2, 1'b0, 1'b1);
    waitReqValid(ok);
    sync_req_ready_i = 1'b1;
    step();
    sync_req_ready_i = 1'b0;
    driveRsp(2'd1, 3'd5, 1'b0);
    step();
    sync_rsp_valid_i = 1'b0;
    checkOutput("stray_wrong_id", stray_o, 1);
    checkOutput("no_rsp_wrong_id", core_rsp_valid_o, 0);
    driveRsp(2'd2, 3'd2, 1'b0);
    step();
    sync_rsp_valid_i = 1'b0;
    checkOutput("stray_wrong_level", stray_o, 1);
    checkOutput("no_rsp_wrong_level", core_rsp_valid_o, 0);
    step();
    checkOutput("stray_quiet", stray_o, 0);
    driveRsp(2'd1, 3'd2, 1'b0);
    step();
    sync_rsp_valid_i = 1'b0;
    checkOutput("match_rsp_valid", core_rsp_valid_o, 1);
    checkOutput("match_no_stray", stray_o, 0);
    step();
    driveRsp(2'd0, 3'd0, 1'b0);
    step();
    sync_rsp_valid_i = 1'b0;
    checkOutput("stray_idle", stray_o, 1);

    $display("[TB] error propagation");
    applyStimulus(2'd3, 3'd6, 1'b1, 1'b1);
    serveOne(2'd3, 3'd6, 3, 1'b1, 4);

    $display("[TB] timeout");
    applyStimulus(2'd0, 3'd4, 1'b1, 1'b1);
    serveOne(2'd0, 3'd4, 0, 1'b0, 9);
    applyStimulus(2'd2, 3'd1, 1'b0, 1'b1);
    serveOne(2'd2, 3'd1, TMO, 1'b0, 9);

    $display("[TB] reset mid-wait");
    applyStimulus(2'd1, 3'd3, 1'b0, 1'b0);
    applyStimulus(2'd2, 3'd5, 1'b0, 1'b0);
    waitReqValid(ok);
    sync_req_ready_i = 1'b1;
    step();
    sync_req_ready_i = 1'b0;
    driveRsp(2'd0, 3'd7, 1'b0);
    step();
    sync_rsp_valid_i = 1'b0;
    checkOutput("pre_reset_busy", busy_o, 1);
    checkOutput("pre_reset_stray", stray_o, 1);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("rst_sync_valid", sync_req_valid_o, 0);
    checkOutput("rst_sync_level", sync_req_level_o, 0);
    checkOutput("rst_sync_id", sync_req_id_o, 0);
    checkOutput("rst_rsp_valid", core_rsp_valid_o, 0);
    checkOutput("rst_rsp_id", core_rsp_id_o, 0);
    checkOutput("rst_rsp_err", core_rsp_err_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_stray", stray_o, 0);
    checkOutput("rst_timeout", timeout_o, 0);
    checkOutput("rst_ready", core_req_ready_o, 0);
    step();
    step();
    rst_i = 1'b0;
    #1;
    checkOutput("release_ready", core_req_ready_o, 1);
    for (int k = 0; k < 10; k++) begin
      if (k == 2) driveRsp(2'd1, 3'd3, 1'b0);
      step();
      sync_rsp_valid_i = 1'b0;
      if (k == 2) checkOutput("post_reset_stray", stray_o, 1);
      checkOutput("post_reset_no_rsp", core_rsp_valid_o, 0);
      checkOutput("post_reset_busy", busy_o, 0);
    end
    applyStimulus(2'd1, 3'd3, 1'b0, 1'b1);
    checkOutput("rerun_latency_c1", sync_req_valid_o, 0);
    step();
    checkOutput("rerun_latency_c2", sync_req_valid_o, 1);
    serveOne(2'd1, 3'd3, 5, 1'b0, 6);
    checkOutput("rerun_busy", busy_o, 0);

    $display("[TB] random traffic");
    s0 = stray_seen;
    t0 = timeout_seen;
    fork
      begin : pusher
        plan_t p;
        int issued;
        int guard;
        issued = 0;
        guard = 0;
        while (issued < N_RAND && guard < 20000) begin
          guard++;
          if ($urandom_range(0, 2) != 0) begin
            core_req_valid_i = 1'b1;
            core_req_level_i = LVL_W'($urandom_range(0, 3));
            core_req_id_i    = ID_W'($urandom_range(0, 7));
            if (core_req_ready_o) begin
              p.level  = core_req_level_i;
              p.id     = core_req_id_i;
              p.rsp_at = $urandom_range(1, 12);
              p.err    = 1'($urandom_range(0, 1));
              plan_q.push_back(p);
              exp_q.push_back('{id: p.id, err: (p.rsp_at <= TMO) ? p.err : 1'b1});
              issued++;
            end
          end else begin
            core_req_valid_i = 1'b0;
          end
          step();
        end
        core_req_valid_i = 1'b0;
        if (issued < N_RAND) recordFail("rand_issue", "got fewer accepted requests than planned");
      end
      begin : network
        plan_t q;
        bit nok;
        logic [LVL_W-1:0] rl;
        logic [ID_W-1:0]  ri;
        for (int n = 0; n < N_RAND; n++) begin
          waitReqValid(nok);
          if (!nok) break;
          repeat ($urandom_range(0, 2)) step();
          if (plan_q.size() == 0) begin
            recordFail("rand_plan", "got a network request with no planned barrier");
            break;
          end
          q = plan_q.pop_front();
          checkOutput("rand_req_level", sync_req_level_o, q.level);
          checkOutput("rand_req_id", sync_req_id_o, q.id);
          sync_req_ready_i = 1'b1;
          step();
          sync_req_ready_i = 1'b0;
          for (int j = 1; j <= q.rsp_at; j++) begin
            if (j == q.rsp_at) begin
              driveRsp(q.level, q.id, q.err);
              if (j > TMO) exp_stray++;
            end else if ($urandom_range(0, 3) == 0) begin
              rl = LVL_W'($urandom_range(0, 3));
              ri = ID_W'($urandom_range(0, 7));
              if (rl == q.level && ri == q.id) ri = ri + ID_W'(1);
              driveRsp(rl, ri, 1'b0);
              exp_stray++;
            end
            step();
            sync_rsp_valid_i = 1'b0;
          end
          if (q.rsp_at > TMO) exp_timeout++;
        end
        net_done = 1'b1;
      end
      begin : rsp_ready_driver
        while (!net_done) begin
          core_rsp_ready_i = 1'($urandom_range(0, 1));
          step();
        end
        core_rsp_ready_i = 1'b1;
      end
    join

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    step();
    step();
    checkOutput("sb_drained", exp_q.size(), 0);
    checkOutput("rand_stray_count", stray_seen - s0, exp_stray);
    checkOutput("rand_timeout_count", timeout_seen - t0, exp_timeout);
    checkOutput("rand_final_busy", busy_o, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
